// File: rtl/bf_pkg.sv
// Shared definitions for the BF instruction sequencer.
// Opcode values, sequencer states and the default nesting-counter width.
package bf_pkg;

   localparam int DEPTH_WIDTH_DEF = 4;

   localparam logic [3:0] OP_NOP     = 4'h0;
   localparam logic [3:0] OP_PTR_INC = 4'h1;
   localparam logic [3:0] OP_PTR_DEC = 4'h2;
   localparam logic [3:0] OP_INC     = 4'h3;
   localparam logic [3:0] OP_DEC     = 4'h4;
   localparam logic [3:0] OP_OUT     = 4'h5;
   localparam logic [3:0] OP_IN      = 4'h6;
   localparam logic [3:0] OP_LSTART  = 4'h7;
   localparam logic [3:0] OP_LEND    = 4'h8;
   localparam logic [3:0] OP_HALT    = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_SCAN_FWD,
      S_SCAN_BACK,
      S_DONE
   } state_t;

endpackage

// File: rtl/bf_loop_stack.sv
// LIFO of loop return addresses (the pc of each taken LOOP_START).
// Only built when BF_LOOP_STACK_EN is defined.
module bf_loop_stack
   import bf_pkg::*;
#(
   parameter int ADDR_WIDTH  = 8,
   parameter int DEPTH_WIDTH = DEPTH_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic                  pop,
   input  logic [ADDR_WIDTH-1:0] push_data,
   output logic [ADDR_WIDTH-1:0] top,
   output logic                  full,
   output logic                  empty
);

   localparam int ENTRIES = 2 ** DEPTH_WIDTH;

   logic [ADDR_WIDTH-1:0]  mem [ENTRIES];
   logic [DEPTH_WIDTH:0]   count;
   logic [DEPTH_WIDTH-1:0] top_idx;

   assign full    = (count == (DEPTH_WIDTH+1)'(ENTRIES));
   assign empty   = (count == '0);
   assign top_idx = count[DEPTH_WIDTH-1:0] - 1'b1;
   assign top     = mem[top_idx];

   // Occupancy counter; reset empties the stack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (push && !full) begin
         count <= count + 1'b1;
      end else if (pop && !empty) begin
         count <= count - 1'b1;
      end
   end

   // Entry storage; contents above count are don't-care.
   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[count[DEPTH_WIDTH-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/bf_fetch_ctrl.sv
// BF instruction sequencer: pc, opcode decode, bracket resolution.
// Optional BF_LOOP_STACK_EN replaces backward scans with a return stack.
module bf_fetch_ctrl
   import bf_pkg::*;
#(
   parameter int DATA_WIDTH  = 4,
   parameter int ADDR_WIDTH  = 8,
   parameter int DEPTH_WIDTH = DEPTH_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic                  exec_valid,
   output logic [DATA_WIDTH-1:0] exec_op,
   input  logic                  exec_ready,
   input  logic                  cell_zero,
   output logic                  halted,
   output logic                  error
);

   state_t                 state, state_d;
   logic [ADDR_WIDTH-1:0]  pc, pc_d;
   logic [DEPTH_WIDTH-1:0] depth, depth_d;
   logic                   err_q, err_d;
   logic                   fault;
   logic                   is_exec, is_ls, is_le, is_halt;
   logic                   pc_max, pc_min, dep_max, dep_one;

`ifdef BF_LOOP_STACK_EN
   logic                  push, pop;
   logic                  stk_full, stk_empty;
   logic [ADDR_WIDTH-1:0] stk_top;

   bf_loop_stack #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .DEPTH_WIDTH (DEPTH_WIDTH)
   ) u_stack (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .pop       (pop),
      .push_data (pc),
      .top       (stk_top),
      .full      (stk_full),
      .empty     (stk_empty)
   );
`endif

   assign rom_addr = pc;
   assign halted   = (state == S_DONE);
   assign error    = err_q;

   assign is_exec = (rom_data >= DATA_WIDTH'(OP_PTR_INC))
                 && (rom_data <= DATA_WIDTH'(OP_IN));
   assign is_ls   = (rom_data == DATA_WIDTH'(OP_LSTART));
   assign is_le   = (rom_data == DATA_WIDTH'(OP_LEND));
   assign is_halt = (rom_data == DATA_WIDTH'(OP_HALT));

   assign pc_max  = &pc;
   assign pc_min  = (pc == '0);
   assign dep_max = &depth;
   assign dep_one = (depth == DEPTH_WIDTH'(1));

   // Sequencer state, pc, nesting depth and sticky error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         pc    <= '0;
         depth <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_d;
         pc    <= pc_d;
         depth <= depth_d;
         err_q <= err_d;
      end
   end

   // Next state, pc/depth update, issue handshake; faults hold pc.
   always_comb begin
      state_d    = state;
      pc_d       = pc;
      depth_d    = depth;
      err_d      = err_q;
      fault      = 1'b0;
      exec_valid = 1'b0;
      exec_op    = '0;
`ifdef BF_LOOP_STACK_EN
      push       = 1'b0;
      pop        = 1'b0;
`endif
      unique case (state)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               pc_d    = '0;
               depth_d = '0;
            end
         end
         S_RUN: begin
            unique case (1'b1)
               is_exec: begin
                  exec_valid = 1'b1;
                  exec_op    = rom_data;
                  if (exec_ready) begin
                     if (pc_max) fault = 1'b1;
                     else        pc_d  = pc + 1'b1;
                  end
               end
               is_ls: begin
                  if (cell_zero) begin
                     if (pc_max) begin
                        fault = 1'b1;
                     end else begin
                        depth_d = DEPTH_WIDTH'(1);
                        pc_d    = pc + 1'b1;
                        state_d = S_SCAN_FWD;
                     end
                  end else begin
`ifdef BF_LOOP_STACK_EN
                     if (stk_full) fault = 1'b1;
                     else          push  = 1'b1;
`endif
                     if (pc_max) fault = 1'b1;
                     else        pc_d  = pc + 1'b1;
                  end
               end
               is_le: begin
`ifdef BF_LOOP_STACK_EN
                  if (stk_empty) begin
                     fault = 1'b1;
                  end else if (!cell_zero) begin
                     if (&stk_top) fault = 1'b1;
                     else          pc_d  = stk_top + 1'b1;
                  end else begin
                     pop = 1'b1;
                     if (pc_max) fault = 1'b1;
                     else        pc_d  = pc + 1'b1;
                  end
`else
                  if (!cell_zero) begin
                     if (pc_min) begin
                        fault = 1'b1;
                     end else begin
                        depth_d = DEPTH_WIDTH'(1);
                        pc_d    = pc - 1'b1;
                        state_d = S_SCAN_BACK;
                     end
                  end else begin
                     if (pc_max) fault = 1'b1;
                     else        pc_d  = pc + 1'b1;
                  end
`endif
               end
               is_halt: begin
                  state_d = S_DONE;
               end
               default: begin
                  if (pc_max) fault = 1'b1;
                  else        pc_d  = pc + 1'b1;
               end
            endcase
         end
         S_SCAN_FWD: begin
            if (pc_max) fault = 1'b1;
            else        pc_d  = pc + 1'b1;
            unique case (1'b1)
               is_ls: begin
                  if (dep_max) fault   = 1'b1;
                  else         depth_d = depth + 1'b1;
               end
               is_le: begin
                  if (dep_one) state_d = S_RUN;
                  else         depth_d = depth - 1'b1;
               end
               default: ;
            endcase
         end
         S_SCAN_BACK: begin
            unique case (1'b1)
               is_ls && dep_one: begin
                  if (pc_max) begin
                     fault = 1'b1;
                  end else begin
                     pc_d    = pc + 1'b1;
                     state_d = S_RUN;
                  end
               end
               default: begin
                  if (pc_min) fault = 1'b1;
                  else        pc_d  = pc - 1'b1;
                  if (is_le) begin
                     if (dep_max) fault   = 1'b1;
                     else         depth_d = depth + 1'b1;
                  end else if (is_ls) begin
                     depth_d = depth - 1'b1;
                  end
               end
            endcase
         end
         S_DONE: ;
         default: state_d = S_DONE;
      endcase
      if (fault) begin
         err_d   = 1'b1;
         state_d = S_DONE;
         pc_d    = pc;
         depth_d = depth;
`ifdef BF_LOOP_STACK_EN
         push    = 1'b0;
         pop     = 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_bf_fetch_ctrl.sv
// Directed bench for bf_fetch_ctrl; second instance uses DEPTH_WIDTH=2.
// Follows BF_LOOP_STACK_EN for the backward-loop pc trace.
module tb_bf_fetch_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       exec_ready = 1'b1;
   logic       cell_zero = 1'b0;
   logic [7:0] rom_addr, rom_addr2;
   logic [3:0] rom_data, rom_data2;
   logic [3:0] exec_op, exec_op2;
   logic       exec_valid, exec_valid2;
   logic       halted, halted2;
   logic       error, error2;
   logic [3:0] rom  [256];
   logic [3:0] rom2 [256];
   int         checks = 0;
   int         errors = 0;
   int         tr_pc[$];
   int         tr_v[$];
   int         tr_cz[$];

   assign rom_data  = rom[rom_addr];
   assign rom_data2 = rom2[rom_addr2];

   always #5 clk = ~clk;

   bf_fetch_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .exec_valid (exec_valid),
      .exec_op    (exec_op),
      .exec_ready (exec_ready),
      .cell_zero  (cell_zero),
      .halted     (halted),
      .error      (error)
   );

   bf_fetch_ctrl #(.DEPTH_WIDTH(2)) dut2 (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .rom_addr   (rom_addr2),
      .rom_data   (rom_data2),
      .exec_valid (exec_valid2),
      .exec_op    (exec_op2),
      .exec_ready (exec_ready),
      .cell_zero  (cell_zero),
      .halted     (halted2),
      .error      (error2)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_roms();
      for (int i = 0; i < 256; i++) begin
         rom[i]  = 4'h0;
         rom2[i] = 4'h0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic start_prog();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      clear_roms();
      #2;
      chk("rst_addr",   rom_addr,   0);
      chk("rst_valid",  exec_valid, 0);
      chk("rst_op",     exec_op,    0);
      chk("rst_halted", halted,     0);
      chk("rst_error",  error,      0);

      // "+ + . HALT", ready tied high
      rom[0] = 4'h3; rom[1] = 4'h3; rom[2] = 4'h5; rom[3] = 4'hF;
      exec_ready = 1'b1;
      do_reset();
      repeat (3) @(negedge clk);
      chk("idle_ignore", rom_addr, 0);
      chk("idle_valid",  exec_valid, 0);
      start_prog();
      chk("t1_v0",  exec_valid, 1);
      chk("t1_op0", exec_op, 3);
      @(negedge clk);
      chk("t1_a1",  rom_addr, 1);
      chk("t1_op1", exec_op, 3);
      @(negedge clk);
      chk("t1_a2",  rom_addr, 2);
      chk("t1_op2", exec_op, 5);
      @(negedge clk);
      chk("t1_a3",  rom_addr, 3);
      chk("t1_v3",  exec_valid, 0);
      chk("t1_h3",  halted, 0);
      @(negedge clk);
      chk("t1_halt", halted, 1);
      chk("t1_err",  error, 0);
      chk("t1_vd",   exec_valid, 0);

      // stall on first INC
      do_reset();
      exec_ready = 1'b0;
      start_prog();
      for (int i = 0; i < 3; i++) begin
         chk("t2_v",  exec_valid, 1);
         chk("t2_a",  rom_addr, 0);
         chk("t2_op", exec_op, 3);
         @(negedge clk);
      end
      exec_ready = 1'b1;
      chk("t2_a_rdy", rom_addr, 0);
      @(negedge clk);
      chk("t2_adv", rom_addr, 1);

      // "[ + [ - ] ] . HALT", skip the loop
      clear_roms();
      rom[0] = 4'h7; rom[1] = 4'h3; rom[2] = 4'h7; rom[3] = 4'h4;
      rom[4] = 4'h8; rom[5] = 4'h8; rom[6] = 4'h5; rom[7] = 4'hF;
      cell_zero = 1'b1;
      do_reset();
      start_prog();
      for (int i = 0; i < 6; i++) begin
         chk("t3_noissue", exec_valid, 0);
         @(negedge clk);
      end
      chk("t3_a6",  rom_addr, 6);
      chk("t3_v6",  exec_valid, 1);
      chk("t3_op6", exec_op, 5);
      @(negedge clk);
      @(negedge clk);
      chk("t3_halt", halted, 1);
      chk("t3_err",  error, 0);

      // "+ [ - ] HALT", loop taken twice
      clear_roms();
      rom[0] = 4'h3; rom[1] = 4'h7; rom[2] = 4'h4;
      rom[3] = 4'h8; rom[4] = 4'hF;
`ifdef BF_LOOP_STACK_EN
      tr_pc = '{0, 1, 2, 3, 2, 3, 2, 3, 4};
      tr_v  = '{1, 0, 1, 0, 1, 0, 1, 0, 0};
      tr_cz = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
`else
      tr_pc = '{0, 1, 2, 3, 2, 1, 2, 3, 2, 1, 2, 3, 4};
      tr_v  = '{1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
      tr_cz = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
`endif
      cell_zero = 1'b0;
      do_reset();
      start_prog();
      for (int i = 0; i < tr_pc.size(); i++) begin
         chk($sformatf("t4_pc%0d", i), rom_addr, tr_pc[i]);
         chk($sformatf("t4_v%0d", i), exec_valid, tr_v[i]);
         cell_zero = tr_cz[i][0];
         @(negedge clk);
      end
      chk("t4_halt", halted, 1);
      chk("t4_err",  error, 0);

      // "[" only: forward scan runs off the end of the pc
      clear_roms();
      rom[0] = 4'h7;
      cell_zero = 1'b1;
      do_reset();
      start_prog();
      for (int i = 0; i < 400 && !halted; i++) @(negedge clk);
      chk("t5_halt", halted, 1);
      chk("t5_err",  error, 1);
      chk("t5_pc",   rom_addr, 255);

      // reset in the middle of a scan
      do_reset();
      chk("t5_rst_err", error, 0);
      start_prog();
      repeat (50) @(negedge clk);
      chk("t5_mid_pc", rom_addr, 50);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_ar_addr",  rom_addr, 0);
      chk("t5_ar_valid", exec_valid, 0);
      chk("t5_ar_op",    exec_op, 0);
      chk("t5_ar_halt",  halted, 0);
      chk("t5_ar_err",   error, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // DEPTH_WIDTH=2 instance: 4 nested "[" while skipping
      clear_roms();
      rom2[0] = 4'h7; rom2[1] = 4'h7; rom2[2] = 4'h7; rom2[3] = 4'h7;
      cell_zero = 1'b1;
      do_reset();
      start_prog();
      repeat (3) @(negedge clk);
      chk("t6_a3",   rom_addr2, 3);
      chk("t6_err3", error2, 0);
      @(negedge clk);
      chk("t6_err",  error2, 1);
      chk("t6_halt", halted2, 1);
      chk("t6_pc",   rom_addr2, 3);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
